// File: rtl/control_unit_types_pkg.sv
// Shared control-unit types: opfunc encoding plus the branch-predictor
// metadata that travels from fetch to resolve.
package control_unit_types_pkg;

  typedef enum logic [3:0] {
    OADD, OSUB, OAND, OOR, OXOR, OSLT, OSLL, OSRL,
    OLW,  OSW,  OBEQ, OBNE, OJAL, OJALR, OLUI, ONOP
  } opfunc_t;

  // Sized for the default INDEX_W=2 predictor instantiation.
  localparam int PRED_IDX_W = 2;

  typedef struct packed {
    logic [PRED_IDX_W-1:0] idx;
    logic                  pred;
  } pred_meta_t;

  function automatic logic is_cond_branch(opfunc_t op);
    return (op == OBEQ) || (op == OBNE);
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// One W-bit saturating up/down counter of the pattern history table,
// loaded with a caller-supplied value on reset.
module bp_sat_counter #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] init,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (up && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + W'(1);
      end else if (!up && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= init;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor_table.sv
// Pattern-history-table branch predictor: combinational lookup from fetch,
// registered training from resolve, optional gshare history and miss stats.
module branch_predictor_table
  import control_unit_types_pkg::*;
#(
  parameter int INDEX_W = 2,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 0,
  parameter int STAT_W  = 16
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic [INDEX_W-1:0]                   lk_pcidx,
  output logic                                 lk_taken,
  output logic [INDEX_W-1:0]                   lk_idx,
  input  logic                                 up_valid,
  input  opfunc_t                              up_opfunc,
  input  logic [INDEX_W-1:0]                   up_idx,
  input  logic                                 up_taken,
  input  logic                                 up_pred,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] ghist,
  output logic [STAT_W-1:0]                    miss_cnt
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int GH_W  = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic                 train;
  logic [CNT_W-1:0]     cnt [DEPTH];
  logic [STAT_W-1:0]    miss_q, miss_d;

  assign train = up_valid && is_cond_branch(up_opfunc);

  for (genvar g = 0; g < DEPTH; g++) begin : g_pht
    bp_sat_counter #(.W(CNT_W)) u_cnt (
      .CLK  (CLK),
      .nRST (nRST),
      .en   (train && (up_idx == INDEX_W'(g))),
      .up   (up_taken),
      .init (CNT_INIT),
      .cnt  (cnt[g])
    );
  end

  // History is non-speculative: it only shifts when a branch resolves.
  if (HIST_W > 0) begin : g_gshare
    logic [GH_W-1:0] ghist_q, ghist_d;

    always_comb begin
      ghist_d = ghist_q;
      if (train) begin
        ghist_d = GH_W'({ghist_q, up_taken});
      end
    end

    always_ff @(posedge CLK) begin
      if (!nRST) begin
        ghist_q <= '0;
      end else begin
        ghist_q <= ghist_d;
      end
    end

    assign ghist  = ghist_q;
    assign lk_idx = lk_pcidx ^ INDEX_W'(ghist_q);
  end else begin : g_pc_index
    assign ghist  = '0;
    assign lk_idx = lk_pcidx;
  end

  assign lk_taken = cnt[lk_idx][CNT_W-1];

  always_comb begin
    miss_d = miss_q;
    if (train && (up_taken != up_pred) && (miss_q != STAT_MAX)) begin
      miss_d = miss_q + STAT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Drives a plain-indexed and a gshare predictor with shared stimulus and
// compares both against an arithmetic model of the predictor rules.
module tb_branch_predictor_table;
   import control_unit_types_pkg::*;

   logic       clock = 1'b0;
   logic       nRst;
   logic [2:0] lkPcidx;
   logic [2:0] upIdx;
   logic       upValid;
   opfunc_t    upOpfunc;
   logic       upTaken;
   logic       upPred;

   logic        lkTakenA;
   logic [1:0]  lkIdxA;
   logic [0:0]  ghistA;
   logic [15:0] missA;
   logic        lkTakenB;
   logic [2:0]  lkIdxB;
   logic [1:0]  ghistB;
   logic [1:0]  missB;

   int compareCount  = 0;
   int mismatchCount = 0;

   int mdlCnt [2][8];
   int mdlHist [2];
   int mdlMiss [2];

   // Instance A: defaults (plain PC indexing); instance B: gshare, wider table, tiny stats
   branch_predictor_table dutA (
      .CLK(clock), .nRST(nRst),
      .lk_pcidx(lkPcidx[1:0]), .lk_taken(lkTakenA), .lk_idx(lkIdxA),
      .up_valid(upValid), .up_opfunc(upOpfunc), .up_idx(upIdx[1:0]),
      .up_taken(upTaken), .up_pred(upPred),
      .ghist(ghistA), .miss_cnt(missA)
   );

   branch_predictor_table #(.INDEX_W(3), .CNT_W(3), .HIST_W(2), .STAT_W(2)) dutB (
      .CLK(clock), .nRST(nRst),
      .lk_pcidx(lkPcidx), .lk_taken(lkTakenB), .lk_idx(lkIdxB),
      .up_valid(upValid), .up_opfunc(upOpfunc), .up_idx(upIdx),
      .up_taken(upTaken), .up_pred(upPred),
      .ghist(ghistB), .miss_cnt(missB)
   );

   // Free-running clock shared by both predictors
   always #5 clock = ~clock;

   function automatic int cfgIdxW(int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int cfgCntW(int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int cfgHistW(int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int cfgStatW(int d);
      return (d == 0) ? 16 : 2;
   endfunction

   function automatic int mdlIdx(int d, int pc);
      return (pc ^ mdlHist[d]) % (1 << cfgIdxW(d));
   endfunction

   function automatic int mdlTaken(int d, int pc);
      return (mdlCnt[d][mdlIdx(d, pc)] >= (1 << (cfgCntW(d) - 1))) ? 1 : 0;
   endfunction

   // Reset: every counter weakly not-taken, history and stats cleared
   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) mdlCnt[d][i] = (1 << (cfgCntW(d) - 1)) - 1;
         mdlHist[d] = 0;
         mdlMiss[d] = 0;
      end
   endtask

   // What a rising edge does to the abstract predictor state
   task automatic modelEdge();
      int i;
      int maxCnt;
      int maxMiss;
      if (!nRst) begin
         modelReset();
      end else if (upValid && (upOpfunc == OBEQ || upOpfunc == OBNE)) begin
         for (int d = 0; d < 2; d++) begin
            i = int'(upIdx) % (1 << cfgIdxW(d));
            maxCnt = (1 << cfgCntW(d)) - 1;
            if (upTaken) mdlCnt[d][i] = (mdlCnt[d][i] < maxCnt) ? mdlCnt[d][i] + 1 : maxCnt;
            else         mdlCnt[d][i] = (mdlCnt[d][i] > 0) ? mdlCnt[d][i] - 1 : 0;
            if (cfgHistW(d) > 0)
               mdlHist[d] = ((mdlHist[d] * 2) + int'(upTaken)) % (1 << cfgHistW(d));
            maxMiss = (1 << cfgStatW(d)) - 1;
            if (upTaken != upPred && mdlMiss[d] < maxMiss) mdlMiss[d] = mdlMiss[d] + 1;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("lkTakenA", int'(lkTakenA), mdlTaken(0, int'(lkPcidx)));
      checkOutput("lkIdxA",   int'(lkIdxA),   mdlIdx(0, int'(lkPcidx)));
      checkOutput("ghistA",   int'(ghistA),   mdlHist[0]);
      checkOutput("missA",    int'(missA),    mdlMiss[0]);
      checkOutput("lkTakenB", int'(lkTakenB), mdlTaken(1, int'(lkPcidx)));
      checkOutput("lkIdxB",   int'(lkIdxB),   mdlIdx(1, int'(lkPcidx)));
      checkOutput("ghistB",   int'(ghistB),   mdlHist[1]);
      checkOutput("missB",    int'(missB),    mdlMiss[1]);
   endtask

   // One cycle: drive at negedge, check pre-edge lookup, then advance the model at posedge
   task automatic applyStimulus(input logic rstn, input logic [2:0] pc, input logic valid,
                                input opfunc_t op, input logic [2:0] idx,
                                input logic taken, input logic pred);
      @(negedge clock);
      nRst     = rstn;
      lkPcidx  = pc;
      upValid  = valid;
      upOpfunc = op;
      upIdx    = idx;
      upTaken  = taken;
      upPred   = pred;
      #1;
      checkAll();
      @(posedge clock);
      modelEdge();
   endtask

   task automatic sweep();
      for (int p = 0; p < 8; p++) applyStimulus(1'b1, 3'(p), 1'b0, OBEQ, 3'd0, 1'b0, 1'b0);
   endtask

   // Directed scenarios first, then a long randomized run with occasional resets
   initial begin
      nRst = 1'b0; lkPcidx = '0; upValid = 1'b0; upOpfunc = ONOP;
      upIdx = '0; upTaken = 1'b0; upPred = 1'b0;
      repeat (2) @(posedge clock);
      modelReset();
      sweep();

      repeat (2) applyStimulus(1'b1, 3'd2, 1'b1, OBEQ, 3'd2, 1'b1, 1'b0);
      #1;
      checkOutput("planMissA", int'(missA), 2);
      sweep();

      repeat (5) applyStimulus(1'b1, 3'd1, 1'b1, OBNE, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 3'd1, 1'b1, OBEQ, 3'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd1, 1'b0, ONOP, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd1, 1'b1, OBEQ, 3'd1, 1'b0, 1'b1);
      sweep();

      repeat (4) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b1, OADD,
                               3'($urandom_range(0, 7)), 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd0, 1'b0, OBNE, 3'd3, 1'b1, 1'b0);
      sweep();

      repeat (2) applyStimulus(1'b0, 3'd0, 1'b0, ONOP, 3'd0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 3'd0, 1'b1, OBEQ, 3'd0, 1'b1, 1'b1);
      #1;
      lkPcidx = 3'd1;
      #1;
      checkOutput("planGhistB", int'(ghistB), 3);
      checkOutput("planGshareIdxB", int'(lkIdxB), 2);
      applyStimulus(1'b1, 3'd1, 1'b1, OBEQ, 3'd2, 1'b1, 1'b1);
      applyStimulus(1'b1, 3'd1, 1'b0, ONOP, 3'd0, 1'b0, 1'b0);

      repeat (4) applyStimulus(1'b1, 3'd5, 1'b1, OBNE, 3'd5, 1'b0, 1'b1);
      #1;
      checkOutput("planMissSatB", int'(missB), 3);
      applyStimulus(1'b0, 3'd5, 1'b1, OBEQ, 3'd5, 1'b1, 1'b0);
      #1;
      checkOutput("planRstMissB", int'(missB), 0);
      checkOutput("planRstGhistB", int'(ghistB), 0);
      sweep();

      for (int n = 0; n < 600; n++) begin
         opfunc_t op;
         if ($urandom_range(0, 9) < 6) op = ($urandom_range(0, 1) == 0) ? OBEQ : OBNE;
         else                          op = opfunc_t'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 49) != 0), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), op, 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised pattern-history-table branch predictor for the fetch stage. It holds 2^INDEX_W saturating counters of CNT_W bits, with optional gshare indexing from a global history register, and a saturating mispredict statistics counter. It answers a combinational lookup from fetch and takes registered training updates from the branch-resolve stage. Only BEQ/BNE resolutions train it.

## Interface
Parameters:
- INDEX_W, 2: table index width; table depth = 2^INDEX_W.
- CNT_W, 2: counter width, 1..4.
- HIST_W, 0: global history length, 0..INDEX_W; 0 = plain PC indexing, >0 = gshare.
- STAT_W, 16: mispredict counter width.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- lk_pcidx  in  INDEX_W  PC index bits from fetch (word-address low bits).
- lk_taken  out  INDEX_W→1  prediction: MSB of the selected counter.
- lk_idx  out  INDEX_W  hashed table index used; fetch carries it down the pipe.
- up_valid  in  1  resolve stage has a branch this cycle.
- up_opfunc  in  opfunc_t  resolved instruction's opfunc.
- up_idx  in  INDEX_W  lk_idx value carried from the matching lookup.
- up_taken  in  1  actual branch outcome.
- up_pred  in  1  lk_taken value carried from the matching lookup.
- ghist  out  max(HIST_W,1)  current global history, for debug; 0 when HIST_W=0.
- miss_cnt  out  STAT_W  number of mispredicted trained branches.

## Operation
- Training enable: train = up_valid & (up_opfunc == OBEQ | up_opfunc == OBNE). All other opfuncs, or up_valid=0, leave all state unchanged.
- Lookup index:
  - HIST_W=0: lk_idx = lk_pcidx.
  - HIST_W>0: lk_idx = lk_pcidx XOR {zero-extended ghist}.
- Lookup value: lk_taken = table[lk_idx][CNT_W-1]. The lookup is pure combinational and reads the stored value.
- Counter update on train:
  - up_taken=1: table[up_idx] increments, saturating at 2^CNT_W-1.
  - up_taken=0: table[up_idx] decrements, saturating at 0.
  - No other entry changes.
- History update on train (HIST_W>0): ghist <= {ghist[HIST_W-2:0], up_taken}. For HIST_W=1, ghist <= up_taken. History is non-speculative; it shifts only at resolve.
- Statistics on train with up_taken != up_pred: miss_cnt increments, saturating at 2^STAT_W-1, with no wrap.

Reset (nRST low at a rising edge):
- Every counter is set to 2^(CNT_W-1)-1, i.e. weakly not-taken (01 for CNT_W=2; 0 for CNT_W=1).
- ghist is set to 0 and miss_cnt is set to 0.
- Reset has priority over a simultaneous train.
- Reset is asserted mid-stream, and the first edge with nRST high resumes normal operation.
- After reset, lk_taken=0 for every index.

## Timing
- Lookup latency is 0 cycles: lk_taken and lk_idx are valid in the same cycle as lk_pcidx, after ghist and table settle.
- A train takes effect at the rising edge of the cycle it is presented. A lookup in the following cycle sees the new counter and ghist.
- A same-cycle lookup and train to the same index returns the pre-update value. There is no bypass.
- Under gshare, a same-cycle lookup hashes with the pre-shift ghist.
- One train per cycle is accepted. Back-to-back trains on consecutive cycles are all applied; there is no stall and no handshake.
- miss_cnt and ghist are registered outputs that change only at edges.

## Structure
- opfunc_t, OBEQ and OBNE come from control_unit_types_pkg.
- Add to the same package: a localparam-free function sat_inc/sat_dec is not shared, so keep saturation local.
- Add to the package: typedef pred_meta_t holding {idx, pred} for the fetch→resolve pipeline registers. Its width follows INDEX_W=2 as the default instantiation.
- Sub-module bp_sat_counter has parameter W and ports CLK, nRST, en, up, init value, and cnt. It is instantiated 2^INDEX_W times via a generate loop, replacing the previous fixed four-instance predictor.
- Output selection is an indexed mux over the generated counters.

## Test plan
- Reset, INDEX_W=2, CNT_W=2, HIST_W=0: hold nRST=0 for 2 cycles, then sweep lk_pcidx 0..3 -> lk_taken=0 everywhere, miss_cnt=0, ghist=0.
- Train idx 2 taken twice (OBEQ, up_pred=0) -> lk_taken[2] goes 1 after the first edge (01→10) and stays 1 after the second (11). miss_cnt=2; the other indices are unchanged.
- Saturation: train idx 1 taken 5 times, then not-taken once -> counter 11 then 10, lk_taken still 1. A second not-taken gives lk_taken=0.
- Filter: up_valid=1 with a non-branch opfunc (e.g. OADD) and up_taken=1, repeated 4 times -> no counter, ghist or miss_cnt change. Then up_valid=0 with OBNE -> no change.
- Gshare, HIST_W=2: reset, then train taken, taken (idx 0) -> ghist=2'b11. lk_pcidx=1 gives lk_idx=2. A same-cycle train plus lookup on the same idx returns the old value.
- Reset mid-stream with STAT_W=2: drive 4 mispredicts -> miss_cnt stays at 3 (saturated). Then assert nRST=0 concurrently with a train -> all state returns to reset values and the train is dropped.
